add_sched: RTL and testbench

Two-port scheduler that shares one `int_fp_add` instance between two requesters (e.g. the two MAC lanes). It arbitrates round-robin and issues at most one op per cycle. It drains the adder pipeline whenever the integer/FP mode must change, because the adder's stage registers are mode-gated. It tracks in-flight ops by tag and returns each result to its owner through a per-port response buffer with credit-based backpressure.

---
 rtl/add_sched_pkg.sv | 23 ++
 rtl/add_sched_if.sv | 41 ++++
 rtl/add_rsp_fifo.sv | 51 +++++
 rtl/add_sched.sv | 184 ++++++++++++++++++
 tb/tb_add_sched.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_sched_pkg.sv
// add_sched_pkg: shared types and constants for the add_sched slice.
package add_sched_pkg;

   localparam int DATA_W = 16;

   localparam logic MODE_INT = 1'b0;
   localparam logic MODE_FP  = 1'b1;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   // Owner of an op: the requesting port.
   typedef logic tag_t;

   // One stage of the in-flight tracker.
   typedef struct packed {
      logic valid;
      tag_t tag;
   } slot_t;

endpackage

// File: rtl/add_sched_if.sv
// add_sched_if: request/response handshakes plus the shared adder hookup.
// slave  = the scheduler side, master = requesters/adder side.
interface add_sched_if;
   import add_sched_pkg::*;

   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0]        req_mode;
   logic [DATA_W-1:0] req_a0;
   logic [DATA_W-1:0] req_b0;
   logic [DATA_W-1:0] req_a1;
   logic [DATA_W-1:0] req_b1;

   logic [1:0]        rsp_valid;
   logic [1:0]        rsp_ready;
   logic [DATA_W-1:0] rsp_c0;
   logic [DATA_W-1:0] rsp_c1;

   logic              add_mode;
   logic              add_issue;
   logic [DATA_W-1:0] add_a;
   logic [DATA_W-1:0] add_b;
   logic [DATA_W-1:0] add_c;

   logic              busy;

   modport slave (
      input  req_valid, req_mode, req_a0, req_b0, req_a1, req_b1,
      input  rsp_ready, add_c,
      output req_ready, rsp_valid, rsp_c0, rsp_c1,
      output add_mode, add_issue, add_a, add_b, busy
   );

   modport master (
      output req_valid, req_mode, req_a0, req_b0, req_a1, req_b1,
      output rsp_ready, add_c,
      input  req_ready, rsp_valid, rsp_c0, rsp_c1,
      input  add_mode, add_issue, add_a, add_b, busy
   );

endinterface

// File: rtl/add_rsp_fifo.sv
// add_rsp_fifo: per-port response buffer. FIFO ordered, exposes occupancy so
// the scheduler can count buffered results against the port's credit limit.
// The head entry is read combinationally and stays put until popped.
module add_rsp_fifo
   import add_sched_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int OW    = $clog2(DEPTH + 1),
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic [OW-1:0]     occ
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              do_rd;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign rd_valid = (occ != '0);
   assign do_rd    = rd_en & rd_valid;
   assign rd_data  = mem[rd_ptr];

   // Storage, pointers and occupancy; reset clears data so the head reads 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= bump(wr_ptr);
         end
         if (do_rd) rd_ptr <= bump(rd_ptr);
         occ <= occ + OW'(wr_en) - OW'(do_rd);
      end
   end

endmodule

// File: rtl/add_sched.sv
// add_sched: round-robin sharing of one int/fp16 adder between two ports.
// Mode changes wait for the adder pipeline to empty because its stage
// registers are gated by mode. Results are routed back by tag into
// per-port response FIFOs; credits (in flight + buffered) bound each port.
// Optional: define ADD_SCHED_STATS_EN for stat_ops / stat_drain counters.
module add_sched
   import add_sched_pkg::*;
#(
   parameter int ADD_LAT   = 4,
   parameter int RSP_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   add_sched_if.slave  bus
`ifdef ADD_SCHED_STATS_EN
   ,
   output logic [31:0] stat_ops,
   output logic [31:0] stat_drain
`endif
);

   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam int SW = CW + 1;

   state_t state, state_d;
   logic   cur_mode, cur_mode_d;
   logic   pend_mode, pend_mode_d;
   logic   last;
   logic   win;
   logic   acc;
   logic   pipe_empty;
   logic [1:0] elig;

   // pipe[0] is the issue stage; pipe[ADD_LAT] lines up with a valid add_c.
   slot_t pipe [ADD_LAT:0];
   slot_t head;

   logic [DATA_W-1:0]      add_a_q;
   logic [DATA_W-1:0]      add_b_q;
   logic [1:0][CW-1:0]     inflight;
   logic [1:0][CW-1:0]     occ;
   logic [1:0]             ret;
   logic [1:0]             rd;
   logic [1:0]             rvld;
   logic [1:0][DATA_W-1:0] rdata;

   assign head = pipe[ADD_LAT];

   // A port may request only while it still holds a free result slot.
   always_comb begin
      elig = '0;
      for (int i = 0; i < 2; i++)
         elig[i] = bus.req_valid[i] &&
                   ((SW'(inflight[i]) + SW'(occ[i])) < SW'(RSP_DEPTH));
   end

   // Pipeline is empty when no stage, including issue, holds an op.
   always_comb begin
      pipe_empty = 1'b1;
      for (int k = 0; k <= ADD_LAT; k++)
         if (pipe[k].valid) pipe_empty = 1'b0;
   end

   // Round-robin: on contention the port that did not win last goes next.
   assign win = (elig == 2'b11) ? ~last : elig[1];

   // Next state and accept decision. A mode mismatch behind live ops parks
   // the winner's mode and drains; nobody else is served meanwhile.
   always_comb begin
      state_d     = state;
      cur_mode_d  = cur_mode;
      pend_mode_d = pend_mode;
      acc         = 1'b0;
      case (state)
         RUN: begin
            if (|elig) begin
               if (bus.req_mode[win] == cur_mode) begin
                  acc = 1'b1;
               end else if (pipe_empty) begin
                  cur_mode_d = bus.req_mode[win];
                  acc        = 1'b1;
               end else begin
                  state_d     = DRAIN;
                  pend_mode_d = bus.req_mode[win];
               end
            end
         end
         DRAIN: begin
            if (pipe_empty) begin
               state_d    = RUN;
               cur_mode_d = pend_mode;
            end
         end
         default: state_d = RUN;
      endcase
      // Nothing handshakes while reset is held.
      if (!rst) acc = 1'b0;
   end

   // FSM and mode registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         cur_mode  <= MODE_INT;
         pend_mode <= MODE_INT;
      end else begin
         state     <= state_d;
         cur_mode  <= cur_mode_d;
         pend_mode <= pend_mode_d;
      end
   end

   // Issue stage, tag pipeline and arbitration pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k <= ADD_LAT; k++) pipe[k] <= '0;
         add_a_q <= '0;
         add_b_q <= '0;
         last    <= 1'b1;
      end else begin
         pipe[0].valid <= acc;
         pipe[0].tag   <= win;
         for (int k = 1; k <= ADD_LAT; k++) pipe[k] <= pipe[k-1];
         if (acc) begin
            last    <= win;
            add_a_q <= win ? bus.req_a1 : bus.req_a0;
            add_b_q <= win ? bus.req_b1 : bus.req_b0;
         end
      end
   end

   // In-flight counts: +1 on accept, -1 on retire, net when both happen.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight <= '0;
      end else begin
         for (int i = 0; i < 2; i++)
            inflight[i] <= inflight[i]
                         + CW'(acc && (win == tag_t'(i)))
                         - CW'(ret[i]);
      end
   end

   // Per-port retire routing and response buffers.
   for (genvar i = 0; i < 2; i++) begin : g_port
      assign ret[i] = head.valid && (head.tag == tag_t'(i));
      assign rd[i]  = rvld[i] & bus.rsp_ready[i];

      add_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .wr_en    (ret[i]),
         .wr_data  (bus.add_c),
         .rd_en    (rd[i]),
         .rd_data  (rdata[i]),
         .rd_valid (rvld[i]),
         .occ      (occ[i])
      );
   end

   assign bus.req_ready = acc ? (win ? 2'b10 : 2'b01) : 2'b00;
   assign bus.add_issue = pipe[0].valid;
   assign bus.add_mode  = cur_mode;
   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;
   assign bus.rsp_valid = rvld;
   assign bus.rsp_c0    = rdata[0];
   assign bus.rsp_c1    = rdata[1];
   assign bus.busy      = (|inflight) | (|occ);

`ifdef ADD_SCHED_STATS_EN
   // Saturating counters: accepted ops and cycles spent draining.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_ops   <= '0;
         stat_drain <= '0;
      end else begin
         if (acc && (stat_ops != '1))               stat_ops   <= stat_ops + 32'd1;
         if ((state == DRAIN) && (stat_drain != '1)) stat_drain <= stat_drain + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_add_sched.sv
// tb_add_sched: directed stimulus, a transaction-level model of the
// scheduler, and a stub adder with ADD_LAT latency.
module tb_add_sched;
   import add_sched_pkg::*;

   localparam int ADD_LAT   = 4;
   localparam int RSP_DEPTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   add_sched_if bus();

`ifdef ADD_SCHED_STATS_EN
   logic [31:0] stat_ops;
   logic [31:0] stat_drain;
`endif

   add_sched #(.ADD_LAT(ADD_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef ADD_SCHED_STATS_EN
      ,
      .stat_ops   (stat_ops),
      .stat_drain (stat_drain)
`endif
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Stub adder: int = wrap-around sum; fp16 only needs 1.0+1.0 = 2.0 here,
   // other fp pairs get an arbitrary but distinct result.
   function automatic logic [15:0] stub_add(input logic m, input logic [15:0] a, input logic [15:0] b);
      if (!m) return a + b;
      if (a == 16'h3C00 && b == 16'h3C00) return 16'h4000;
      return a ^ b ^ 16'h8000;
   endfunction

   logic [15:0] st [ADD_LAT];
   always @(posedge clk) begin
      for (int k = ADD_LAT - 1; k > 0; k--) st[k] <= st[k-1];
      st[0] <= bus.add_issue ? stub_add(bus.add_mode, bus.add_a, bus.add_b) : 16'h0;
   end
   assign bus.add_c = st[ADD_LAT-1];

   // ---------------- model ----------------
   typedef struct {
      int          port;
      int          wr_cyc;
      logic [15:0] res;
   } op_t;

   op_t         outq[$];
   logic [15:0] bufq0[$];
   logic [15:0] bufq1[$];
   int          cyc;
   logic        m_mode, m_pend, m_last, m_drain, e_issue;
   logic [15:0] e_a, e_b;
   int          m_ops, m_drains;

   task automatic model_reset();
      outq.delete(); bufq0.delete(); bufq1.delete();
      m_mode = 1'b0; m_pend = 1'b0; m_last = 1'b1; m_drain = 1'b0;
      e_issue = 1'b0; e_a = '0; e_b = '0;
      m_ops = 0; m_drains = 0;
   endtask

   // One compare process: predict this cycle's outputs, check, then advance.
   always @(negedge clk) begin : cmp
      int          c0, c1;
      logic [1:0]  elig, e_ready, e_rv;
      logic        w, rmode, empty, acc, go_sw, go_drain;
      logic [15:0] oa, ob;
      op_t         o;
      if (!rst) begin
         model_reset();
         chk("rst req_ready", bus.req_ready, 0);
         chk("rst rsp_valid", bus.rsp_valid, 0);
         chk("rst add_issue", bus.add_issue, 0);
         chk("rst add_mode",  bus.add_mode, 0);
         chk("rst add_a",     bus.add_a, 0);
         chk("rst add_b",     bus.add_b, 0);
         chk("rst rsp_c0",    bus.rsp_c0, 0);
         chk("rst rsp_c1",    bus.rsp_c1, 0);
         chk("rst busy",      bus.busy, 0);
      end else begin
         c0 = bufq0.size(); c1 = bufq1.size();
         foreach (outq[k]) if (outq[k].port == 0) c0++; else c1++;
         elig  = {bus.req_valid[1] && (c1 < RSP_DEPTH), bus.req_valid[0] && (c0 < RSP_DEPTH)};
         empty = (outq.size() == 0);
         w     = (elig == 2'b11) ? !m_last : elig[1];
         rmode = bus.req_mode[w];
         acc = 1'b0; go_sw = 1'b0; go_drain = 1'b0;
         if (!m_drain && elig != 2'b00) begin
            if (rmode == m_mode) acc = 1'b1;
            else if (empty) begin acc = 1'b1; go_sw = 1'b1; end
            else go_drain = 1'b1;
         end
         e_ready = acc ? (w ? 2'b10 : 2'b01) : 2'b00;
         e_rv    = {bufq1.size() > 0, bufq0.size() > 0};

         chk("req_ready", bus.req_ready, e_ready);
         chk("add_issue", bus.add_issue, e_issue);
         chk("add_mode",  bus.add_mode, m_mode);
         chk("add_a",     bus.add_a, e_a);
         chk("add_b",     bus.add_b, e_b);
         chk("rsp_valid", bus.rsp_valid, e_rv);
         if (e_rv[0]) chk("rsp_c0", bus.rsp_c0, bufq0[0]);
         if (e_rv[1]) chk("rsp_c1", bus.rsp_c1, bufq1[0]);
         chk("busy", bus.busy, (outq.size() > 0 || e_rv != 2'b00) ? 1 : 0);
`ifdef ADD_SCHED_STATS_EN
         chk("stat_ops",   stat_ops, m_ops);
         chk("stat_drain", stat_drain, m_drains);
`endif

         // advance one clock
         if (m_drain) begin
            m_drains++;
            if (empty) begin m_drain = 1'b0; m_mode = m_pend; end
         end
         if (go_sw) m_mode = rmode;
         if (go_drain) begin m_drain = 1'b1; m_pend = rmode; end
         e_issue = acc;
         if (acc) begin
            oa = w ? bus.req_a1 : bus.req_a0;
            ob = w ? bus.req_b1 : bus.req_b0;
            m_last = w; m_ops++; e_a = oa; e_b = ob;
            o.port = int'(w); o.wr_cyc = cyc + 1 + ADD_LAT; o.res = stub_add(m_mode, oa, ob);
            outq.push_back(o);
         end
         if (e_rv[0] && bus.rsp_ready[0]) void'(bufq0.pop_front());
         if (e_rv[1] && bus.rsp_ready[1]) void'(bufq1.pop_front());
         while (outq.size() > 0 && outq[0].wr_cyc == cyc) begin
            if (outq[0].port == 0) bufq0.push_back(outq[0].res);
            else                   bufq1.push_back(outq[0].res);
            void'(outq.pop_front());
         end
         cyc++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_req(input logic [1:0] v, input logic [1:0] m,
                          input logic [15:0] a0, input logic [15:0] b0,
                          input logic [15:0] a1, input logic [15:0] b1);
      bus.req_valid = v; bus.req_mode = m;
      bus.req_a0 = a0; bus.req_b0 = b0; bus.req_a1 = a1; bus.req_b1 = b1;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (bus.busy && n < max) begin tick(); n++; end
      chk("idle within budget", bus.busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int n0;
      cyc = 0;
      model_reset();
      set_req(2'b00, 2'b00, 0, 0, 0, 0);
      bus.rsp_ready = 2'b00;
      tick(); tick(); #2;
      chk("lit rst req_ready", bus.req_ready, 0);
      chk("lit rst add_mode",  bus.add_mode, 0);
      chk("lit rst busy",      bus.busy, 0);
      tick(); rst = 1'b1; bus.rsp_ready = 2'b11;

      // fp 1.0 + 1.0 on port 0
      tick(); set_req(2'b01, 2'b01, 16'h3C00, 16'h3C00, 0, 0); #2;
      chk("t1 ready T", bus.req_ready, 2'b01);
      tick(); bus.req_valid = 2'b00; #2;
      chk("t1 issue T+1", bus.add_issue, 1);
      chk("t1 mode T+1",  bus.add_mode, 1);
      chk("t1 add_a T+1", bus.add_a, 16'h3C00);
      repeat (4) tick(); #2;
      chk("t1 rsp_valid T+5", bus.rsp_valid, 2'b00);
      tick(); #2;
      chk("t1 rsp_valid T+6", bus.rsp_valid, 2'b01);
      chk("t1 rsp_c0 T+6",    bus.rsp_c0, 16'h4000);
      tick(); #2;
      chk("t1 busy T+7", bus.busy, 0);

      // both ports stream int ops
      tick(); set_req(2'b11, 2'b00, 16'h0003, 16'h0005, 16'h0010, 16'h0001); #2;
      chk("t2 ready c0", bus.req_ready, 2'b10);
      tick(); #2; chk("t2 ready c1", bus.req_ready, 2'b01);
      tick(); #2; chk("t2 ready c2", bus.req_ready, 2'b10);
      tick(); #2; chk("t2 ready c3", bus.req_ready, 2'b01);
      tick(); #2; chk("t2 ready c4 credits", bus.req_ready, 2'b00);
      repeat (30) tick();
      bus.req_valid = 2'b00;
      wait_idle(50);

      // int op in flight, then fp request forces a drain
      tick(); set_req(2'b01, 2'b00, 16'h0001, 16'h0002, 0, 0); #2;
      chk("t3 ready A", bus.req_ready, 2'b01);
      tick(); set_req(2'b10, 2'b10, 0, 0, 16'h3C00, 16'h3C00); #2;
      chk("t3 ready A+1", bus.req_ready, 2'b00);
      tick(); tick(); tick(); #2;
      chk("t3 ready A+4", bus.req_ready, 2'b00);
      chk("t3 mode A+4",  bus.add_mode, 0);
      tick(); tick(); #2;
      chk("t3 ready A+6", bus.req_ready, 2'b00);
      chk("t3 mode A+6",  bus.add_mode, 0);
      tick(); #2;
      chk("t3 ready A+7", bus.req_ready, 2'b10);
      chk("t3 mode A+7",  bus.add_mode, 1);
      tick(); bus.req_valid = 2'b00; #2;
      chk("t3 issue A+8", bus.add_issue, 1);
      wait_idle(50);

      // port 0 response stalled: credits cap it at two accepts
      tick(); bus.rsp_ready = 2'b10;
      set_req(2'b11, 2'b00, 16'h0007, 16'h0008, 16'h0020, 16'h0002);
      n0 = 0;
      repeat (20) begin
         #2; if (bus.req_valid[0] && bus.req_ready[0]) n0++;
         tick();
      end
      chk("t4 p0 accepts", n0, 2);
      #2; chk("t4 p0 blocked", bus.req_ready[0], 0);
      tick(); bus.req_valid = 2'b00; bus.rsp_ready = 2'b11;
      wait_idle(50);

      // reset with three ops in flight
      tick(); set_req(2'b11, 2'b00, 16'h0100, 16'h0001, 16'h0200, 16'h0002);
      tick(); tick(); tick();
      #1 rst = 1'b0;
      #1;
      chk("t5 busy now",      bus.busy, 0);
      chk("t5 issue now",     bus.add_issue, 0);
      chk("t5 rsp_valid now", bus.rsp_valid, 2'b00);
      chk("t5 ready now",     bus.req_ready, 2'b00);
      chk("t5 add_a now",     bus.add_a, 0);
      tick(); tick();
      rst = 1'b1; #2;
      chk("t5 first after rst", bus.req_ready, 2'b01);
      repeat (15) tick();
      bus.req_valid = 2'b00;
      wait_idle(50);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
